// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch unit's control, ROM and instruction outputs.
//   master : upstream/execute side (drives Start, branch, stall, ROM data)
//   slave  : fetch_unit side (drives Address and the fetched-instruction outputs)
interface fetch_unit_if;
  logic       Start;        // begin fetching at StartAddr (one-cycle pulse)
  logic [7:0] StartAddr;    // first fetch address
  logic       Stall;        // downstream not ready
  logic       BranchEn;     // taken branch from execute
  logic       BranchRel;    // 1: BranchTarget is offset from InstPC
  logic [7:0] BranchTarget; // absolute target or signed offset
  logic [8:0] Instruction;  // combinational ROM data for Address
  logic [7:0] Address;      // ROM address (PC)
  logic [8:0] InstOut;      // registered fetched instruction
  logic [7:0] InstPC;       // address InstOut came from
  logic       InstValid;    // InstOut/InstPC live this cycle
  logic       Halted;       // fetch stopped on halt encoding

  modport master (
    output Start, StartAddr, Stall, BranchEn, BranchRel, BranchTarget, Instruction,
    input  Address, InstOut, InstPC, InstValid, Halted
  );

  modport slave (
    input  Start, StartAddr, Stall, BranchEn, BranchRel, BranchTarget, Instruction,
    output Address, InstOut, InstPC, InstValid, Halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch with stall, absolute/relative
// branch redirect, halt detection and restart.
//   CLK    : rising-edge clock
//   Reset  : asynchronous active-high reset
//   bus    : fetch_unit_if.slave (control inputs, ROM data in, Address and
//            InstOut/InstPC/InstValid/Halted out)
module fetch_unit #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [8:0] HALT_INSN = 9'h1FF
) (
  input logic         CLK,
  input logic         Reset,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc,    w_pc_nxt;
  logic [8:0] r_inst,  w_inst_nxt;
  logic [7:0] r_ipc,   w_ipc_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_halted;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_ipc    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_inst   <= w_inst_nxt;
      r_ipc    <= w_ipc_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;

    unique case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (bus.Start) begin
          w_pc_nxt    = bus.StartAddr;
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.Start) begin
          w_pc_nxt    = bus.StartAddr;
          w_valid_nxt = 1'b0;
        end else if (bus.BranchEn) begin
          // Redirect squashes the instruction currently on the ROM bus,
          // which also masks a halt encoding arriving this cycle.
          w_pc_nxt    = bus.BranchRel ? 8'(r_ipc + bus.BranchTarget) : bus.BranchTarget;
          w_valid_nxt = 1'b0;
        end else if (!bus.Stall) begin
          w_inst_nxt  = bus.Instruction;
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          if (bus.Instruction == HALT_INSN) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = 8'(r_pc + 8'd1);
          end
        end
      end

      S_HALT: begin
        w_valid_nxt = 1'b0;
        if (bus.Start) begin
          w_pc_nxt    = bus.StartAddr;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.Address   = r_pc;
  assign bus.InstOut   = r_inst;
  assign bus.InstPC    = r_ipc;
  assign bus.InstValid = r_valid;
  assign bus.Halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [7:0] RPC  = 8'h00;
  localparam logic [8:0] HALT = 9'h1FF;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC), .HALT_INSN(HALT)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [8:0] rom [256];
  always_comb bus.Instruction = rom[bus.Address];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model: "running" and "halted" flags plus the visible registers.
  logic       m_run, m_halt, m_valid;
  logic [7:0] m_pc, m_ipc;
  logic [8:0] m_inst;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_valid = 0;
    m_pc = RPC; m_ipc = 8'h00; m_inst = 9'h000;
  endtask

  task automatic model_step();
    logic [8:0] ins;
    if (bus.Start) begin
      m_pc = bus.StartAddr; m_valid = 0; m_run = 1; m_halt = 0;
    end else if (m_halt || !m_run) begin
      m_valid = 0;
    end else if (bus.BranchEn) begin
      m_pc = bus.BranchRel ? m_ipc + bus.BranchTarget : bus.BranchTarget;
      m_valid = 0;
    end else if (!bus.Stall) begin
      ins = rom[m_pc];
      m_inst = ins; m_ipc = m_pc; m_valid = 1;
      if (ins == HALT) begin m_halt = 1; m_run = 0; end
      else m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic compare_model();
    chk("Address",   16'(bus.Address),   16'(m_pc));
    chk("InstOut",   16'(bus.InstOut),   16'(m_inst));
    chk("InstPC",    16'(bus.InstPC),    16'(m_ipc));
    chk("InstValid", 16'(bus.InstValid), 16'(m_valid));
    chk("Halted",    16'(bus.Halted),    16'(m_halt));
  endtask

  task automatic drive(input logic s, input logic [7:0] sa, input logic st,
                       input logic be, input logic br, input logic [7:0] bt);
    bus.Start = s; bus.StartAddr = sa; bus.Stall = st;
    bus.BranchEn = be; bus.BranchRel = br; bus.BranchTarget = bt;
  endtask

  // One clock: model advances with the DUT on the edge, outputs compared at negedge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_model();
  endtask

  // Assert reset part-way through a cycle; outputs must clear before the next edge.
  task automatic reset_mid();
    drive(0, 8'h00, 0, 0, 0, 8'h00);
    @(posedge CLK);
    model_step();
    #2 Reset = 1'b1;
    #1;
    chk("rst_Address",   16'(bus.Address),   16'(RPC));
    chk("rst_InstOut",   16'(bus.InstOut),   16'h000);
    chk("rst_InstPC",    16'(bus.InstPC),    16'h00);
    chk("rst_InstValid", 16'(bus.InstValid), 16'h0);
    chk("rst_Halted",    16'(bus.Halted),    16'h0);
    model_reset();
    @(negedge CLK);
    compare_model();
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 510));
    rom[8'h10] = 9'h001; rom[8'h11] = 9'h002; rom[8'h12] = 9'h003;
    rom[8'h05] = HALT;
    model_reset();
    drive(0, 8'h00, 0, 0, 0, 8'h00);
    Reset = 1'b1;
    #1;
    chk("reset_Address", 16'(bus.Address), 16'h00);
    chk("reset_Valid",   16'(bus.InstValid), 16'h0);
    compare_model();
    @(negedge CLK);
    Reset = 1'b0;

    // Idle ignores branch and stall, stays put until Start.
    drive(0, 8'h00, 1, 1, 0, 8'h55);
    tick(); tick();
    chk("idle_Address", 16'(bus.Address), 16'h00);
    chk("idle_Valid",   16'(bus.InstValid), 16'h0);

    // Sequential fetch from 0x10.
    drive(1, 8'h10, 0, 0, 0, 8'h00); tick();
    chk("start_Address", 16'(bus.Address), 16'h10);
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("seq1_InstOut", 16'(bus.InstOut), 16'h001);
    chk("seq1_InstPC",  16'(bus.InstPC),  16'h10);
    tick();
    chk("seq2_InstOut", 16'(bus.InstOut), 16'h002);
    chk("seq2_InstPC",  16'(bus.InstPC),  16'h11);

    // Stall three cycles.
    drive(0, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_InstOut", 16'(bus.InstOut), 16'h002);
      chk("stall_InstPC",  16'(bus.InstPC),  16'h11);
      chk("stall_Valid",   16'(bus.InstValid), 16'h1);
      chk("stall_Address", 16'(bus.Address), 16'h12);
    end
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("resume_InstOut", 16'(bus.InstOut), 16'h003);
    chk("resume_Address", 16'(bus.Address), 16'h13);

    // Wraparound.
    rom[8'hFE] = 9'h0AA; rom[8'hFF] = 9'h0BB; rom[8'h00] = 9'h0CC; rom[8'h01] = 9'h0DD;
    drive(1, 8'hFE, 0, 0, 0, 8'h00); tick();
    chk("wrap0", 16'(bus.Address), 16'hFE);
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("wrap1", 16'(bus.Address), 16'hFF);
    tick(); chk("wrap2", 16'(bus.Address), 16'h00);
    tick(); chk("wrap3", 16'(bus.Address), 16'h01);

    // Relative then absolute branch from InstPC 0x20.
    rom[8'h20] = 9'h011; rom[8'h21] = 9'h012;
    drive(1, 8'h20, 0, 0, 0, 8'h00); tick();
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("br_InstPC", 16'(bus.InstPC), 16'h20);
    drive(0, 8'h00, 1, 1, 1, 8'hFC); tick();
    chk("brrel_Address", 16'(bus.Address), 16'h1C);
    chk("brrel_Bubble",  16'(bus.InstValid), 16'h0);
    drive(0, 8'h00, 0, 1, 0, 8'h40); tick();
    chk("brabs_Address", 16'(bus.Address), 16'h40);
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("brabs_InstPC", 16'(bus.InstPC), 16'h40);

    // Halt at 0x05, branch/stall ignored, restart.
    rom[8'h03] = 9'h031; rom[8'h04] = 9'h032;
    drive(1, 8'h03, 0, 0, 0, 8'h00); tick();
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick(); tick(); tick();
    chk("halt_InstOut", 16'(bus.InstOut), 16'h1FF);
    chk("halt_Valid",   16'(bus.InstValid), 16'h1);
    chk("halt_Halted",  16'(bus.Halted), 16'h1);
    chk("halt_Address", 16'(bus.Address), 16'h05);
    drive(0, 8'h00, 1, 1, 0, 8'h77); tick();
    chk("halt2_Valid",   16'(bus.InstValid), 16'h0);
    chk("halt2_Address", 16'(bus.Address), 16'h05);
    drive(1, 8'h00, 0, 0, 0, 8'h00); tick();
    chk("restart_Halted",  16'(bus.Halted), 16'h0);
    chk("restart_Address", 16'(bus.Address), 16'h00);

    // Branch beats a halt encoding on the ROM bus.
    drive(1, 8'h05, 0, 0, 0, 8'h00); tick();
    drive(0, 8'h00, 0, 1, 0, 8'h30); tick();
    chk("brhalt_Halted",  16'(bus.Halted), 16'h0);
    chk("brhalt_Address", 16'(bus.Address), 16'h30);

    // Reset mid-fetch, then must stay idle without Start.
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick();
    reset_mid();
    drive(0, 8'h00, 0, 0, 0, 8'h00); tick(); tick();
    chk("postrst_Address", 16'(bus.Address), 16'(RPC));

    // Randomized phase with sprinkled halts.
    for (int i = 0; i < 12; i++) rom[$urandom_range(0, 255)] = HALT;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        drive($urandom_range(0, 99) < 4, 8'($urandom), $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 10, 1'($urandom), 8'($urandom));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
